// File: rtl/fifo_sync.sv
// Single-clock synchronous FIFO around an inferred simple dual-port RAM.
// Keeps read/write pointers and an occupancy count, and presents registered
// full/empty/almost flags plus sticky overflow/underflow error flags.
module fifo_sync #(
    parameter int P_NBITS_ADR     = 8,
    parameter int P_NBITS_DATA    = 14,
    parameter int P_AFULL_THRESH  = 2**P_NBITS_ADR - 4,
    parameter int P_AEMPTY_THRESH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [P_NBITS_DATA-1:0] d,
    input  logic                    we,
    input  logic                    re,
    input  logic                    clr_err,
    output logic [P_NBITS_DATA-1:0] q,
    output logic                    q_valid,
    output logic [P_NBITS_ADR:0]    count,
    output logic                    full,
    output logic                    empty,
    output logic                    afull,
    output logic                    aempty,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int                  C_DEPTH    = 2**P_NBITS_ADR;
    localparam logic [P_NBITS_ADR:0] C_FULL_CNT = C_DEPTH[P_NBITS_ADR:0];
    localparam logic [P_NBITS_ADR:0] C_AFULL    = P_AFULL_THRESH[P_NBITS_ADR:0];
    localparam logic [P_NBITS_ADR:0] C_AEMPTY   = P_AEMPTY_THRESH[P_NBITS_ADR:0];

    logic [P_NBITS_DATA-1:0] mem [C_DEPTH];
    logic [P_NBITS_ADR-1:0]  wr_ptr;
    logic [P_NBITS_ADR-1:0]  rd_ptr;
    logic [P_NBITS_ADR:0]    count_next;
    logic                    push_ok;
    logic                    pop_ok;

    // Accept/reject decisions use the registered flags, then derive the next occupancy.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        push_ok    = we && !full;
        pop_ok     = re && !empty;
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_next = count - 1'b1;
        end
    end

    // RAM write port; storage is left uninitialised and is never read before being written.
    always_ff @(posedge clk) begin
        // NOTE: the memory array has no reset so it maps onto block RAM; stale words are unreachable.
        if (!rst && push_ok) begin
            mem[wr_ptr] <= d;
        end
    end

    // Pointers, occupancy, registered read data and read strobe.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            count   <= count_next;
            q_valid <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                q      <= mem[rd_ptr];
            end
        end
    end

    // Status flags registered from the post-edge occupancy, so they never depend on we/re combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            full   <= 1'b0;
            empty  <= 1'b1;
            afull  <= (C_AFULL == '0);
            aempty <= 1'b1;
        end else begin
            full   <= (count_next == C_FULL_CNT);
            empty  <= (count_next == '0);
            afull  <= (count_next >= C_AFULL);
            aempty <= (count_next <= C_AEMPTY);
        end
    end

    // Sticky error flags: a new error on the same edge wins over clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (we && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (re && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync: directed scenarios plus random streaming,
// compared against a queue-based reference model of the FIFO's behaviour.
module tb_fifo_sync;

    localparam int ADR    = 8;
    localparam int DW     = 14;
    localparam int DEPTH  = 256;
    localparam int AFULL  = 252;
    localparam int AEMPTY = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] d = '0;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] q;
    logic          q_valid;
    logic [ADR:0]  count;
    logic          full, empty, afull, aempty, overflow, underflow;

    fifo_sync #(
        .P_NBITS_ADR    (ADR),
        .P_NBITS_DATA   (DW),
        .P_AFULL_THRESH (AFULL),
        .P_AEMPTY_THRESH(AEMPTY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .d        (d),
        .we       (we),
        .re       (re),
        .clr_err  (clr_err),
        .q        (q),
        .q_valid  (q_valid),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .afull    (afull),
        .aempty   (aempty),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    // Reference model: contents as a queue plus expected registered outputs.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q  = '0;
    logic          exp_qv = 1'b0;
    logic          exp_ov = 1'b0;
    logic          exp_un = 1'b0;
    int            popped_cnt;
    logic [DW-1:0] sent[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        check("count",     32'(count),     32'(n));
        check("full",      32'(full),      32'(n == DEPTH));
        check("empty",     32'(empty),     32'(n == 0));
        check("afull",     32'(afull),     32'(n >= AFULL));
        check("aempty",    32'(aempty),    32'(n <= AEMPTY));
        check("q_valid",   32'(q_valid),   32'(exp_qv));
        check("q",         32'(q),         32'(exp_q));
        check("overflow",  32'(overflow),  32'(exp_ov));
        check("underflow", 32'(underflow), 32'(exp_un));
    endtask

    // One clock: drive inputs, advance the model by the FIFO rules, then compare after the edge.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] din,
                        input logic c, input logic rs);
        logic was_full, was_empty;
        we = w; re = r; d = din; clr_err = c; rst = rs;
        @(posedge clk);
        if (rs) begin
            mq.delete();
            exp_q = '0; exp_qv = 1'b0; exp_ov = 1'b0; exp_un = 1'b0;
        end else begin
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            exp_qv = r && !was_empty;
            if (exp_qv) begin
                exp_q = mq.pop_front();
                popped_cnt++;
            end
            if (w && !was_full) begin
                mq.push_back(din);
            end
            exp_ov = (w && was_full)  ? 1'b1 : (c ? 1'b0 : exp_ov);
            exp_un = (r && was_empty) ? 1'b1 : (c ? 1'b0 : exp_un);
        end
        #1;
        check_all();
        we = 1'b0; re = 1'b0; clr_err = 1'b0; rst = 1'b0;
    endtask

    initial begin
        popped_cnt = 0;

        // Reset state.
        phase = "reset";
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Fill 0..255, then one push too many.
        phase = "fill";
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, DW'(i), 1'b0, 1'b0);
        end
        check("fill_count", 32'(count), 32'd256);
        check("fill_full",  32'(full),  32'd1);
        step(1'b1, 1'b0, 14'h1234, 1'b0, 1'b0);
        check("ovf_set",   32'(overflow), 32'd1);
        check("ovf_count", 32'(count),    32'd256);

        // Drain, then one pop too many.
        phase = "drain";
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, '0, 1'b0, 1'b0);
            check("drain_data", 32'(q), 32'(i));
        end
        check("drain_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        check("unf_set",  32'(underflow), 32'd1);
        check("unf_qv",   32'(q_valid),   32'd0);
        check("unf_hold", 32'(q),         32'd255);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Concurrent push/pop at mid occupancy, at empty, and at full.
        phase = "concurrent";
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, DW'($urandom), 1'b0, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, DW'($urandom), 1'b0, 1'b0);
        end
        check("mid_count", 32'(count), 32'd10);
        while (mq.size() > 0) begin
            step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 14'h0abc, 1'b0, 1'b0);
        check("empty_both_count", 32'(count),     32'd1);
        check("empty_both_unf",   32'(underflow), 32'd1);
        check("empty_both_qv",    32'(q_valid),   32'd0);
        while (mq.size() < DEPTH) begin
            step(1'b1, 1'b0, DW'($urandom), 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 14'h2222, 1'b0, 1'b0);
        check("full_both_count", 32'(count),    32'd255);
        check("full_both_ovf",   32'(overflow), 32'd1);
        check("full_both_qv",    32'(q_valid),  32'd1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        while (mq.size() > 0) begin
            step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        end

        // Random streaming through many pointer wraps at low occupancy.
        phase = "wrap";
        sent.delete();
        popped_cnt = 0;
        for (int cyc = 0; cyc < 6000 && (sent.size() < 600 || mq.size() > 0); cyc++) begin
            logic w, r;
            logic [DW-1:0] v;
            w = (sent.size() < 600) && (mq.size() < 3) && ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 1) == 1);
            v = DW'($urandom);
            if (w) sent.push_back(v);
            step(w, r, v, r && mq.size() == 0, 1'b0);
            if (exp_qv) begin
                check("wrap_order", 32'(q), 32'(sent[popped_cnt-1]));
            end
        end
        check("wrap_all_out", 32'(popped_cnt), 32'd600);

        // Reset in the middle of operation.
        phase = "midreset";
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 1'b0, DW'(i + 100), 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 14'h1111, 1'b0, 1'b1);
        check("rst_count", 32'(count),   32'd0);
        check("rst_empty", 32'(empty),   32'd1);
        check("rst_qv",    32'(q_valid), 32'd0);
        check("rst_q",     32'(q),       32'd0);
        step(1'b1, 1'b0, 14'h3fff, 1'b0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        check("rst_after_q", 32'(q), 32'h3fff);

        // clr_err behaviour, including a collision with a new error.
        phase = "clr_err";
        while (mq.size() < DEPTH) begin
            step(1'b1, 1'b0, DW'($urandom), 1'b0, 1'b0);
        end
        step(1'b1, 1'b0, 14'h0001, 1'b0, 1'b0);
        check("ovf_before_clr", 32'(overflow), 32'd1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("ovf_cleared", 32'(overflow), 32'd0);
        step(1'b1, 1'b0, 14'h0002, 1'b1, 1'b0);
        check("ovf_collide", 32'(overflow), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
